// File: rtl/l2_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : l2_arb_pkg                                                    |
// | Purpose  : Shared defaults and the request payload record for the L2     |
// |            bank round-robin request arbiter.                             |
// | Contents : default width constants, req_payload_t (add, wen, wdata, be)  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package l2_arb_pkg;

  localparam int L2_N_CH_DEF   = 4;
  localparam int L2_ADDR_W_DEF = 12;
  localparam int L2_DATA_W_DEF = 32;
  localparam int L2_BE_W_DEF   = L2_DATA_W_DEF / 8;

  // One master's request towards the bank at default widths.
  typedef struct packed {
    logic [L2_ADDR_W_DEF-1:0] add;
    logic                     wen;   // 0 = write, 1 = read
    logic [L2_DATA_W_DEF-1:0] wdata;
    logic [L2_BE_W_DEF-1:0]   be;
  } req_payload_t;

endpackage : l2_arb_pkg
`default_nettype wire

// File: rtl/rr_prio_sel_l2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_prio_sel_l2                                                |
// | Purpose  : Combinational rotating-priority winner select. The first      |
// |            asserted request found scanning upward from 'flag' (wrapping  |
// |            N_CH-1 -> 0) wins. A flag value >= N_CH scans from 0.         |
// | Ports    : req       in  N_CH    request vector                          |
// |            flag      in  FLAG_W  highest-priority index                  |
// |            gnt_oh    out N_CH    one-hot winner (zero when none)         |
// |            gnt_idx   out IDX_W   binary winner index (0 when none)       |
// |            gnt_valid out 1       a winner exists                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rr_prio_sel_l2
  import l2_arb_pkg::*;
#(
  parameter int N_CH   = L2_N_CH_DEF,
  parameter int FLAG_W = $clog2(N_CH),
  parameter int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]   req,
  input  logic [FLAG_W-1:0] flag,
  output logic [N_CH-1:0]   gnt_oh,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_valid
);

  int unsigned w_start;

  // Out-of-range flags collapse to index 0 rather than aliasing modulo N_CH.
  assign w_start = (32'(flag) >= 32'(N_CH)) ? 32'd0 : 32'(flag);

  always_comb begin
    int unsigned k;
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    k         = 32'd0;
    for (int i = 0; i < N_CH; i++) begin
      k = w_start + 32'(i);
      if (k >= 32'(N_CH)) begin
        k = k - 32'(N_CH);
      end
      if (!gnt_valid && req[IDX_W'(k)]) begin
        gnt_valid           = 1'b1;
        gnt_oh[IDX_W'(k)]   = 1'b1;
        gnt_idx             = IDX_W'(k);
      end
    end
  end

endmodule : rr_prio_sel_l2
`default_nettype wire

// File: rtl/rr_arb_req_l2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_arb_req_l2                                                 |
// | Purpose  : Round-robin request arbiter feeding one L2 memory bank.       |
// |            N_CH masters compete; the winner is chosen by rotating        |
// |            priority starting at rr_flag_i.                               |
// | Config   : L2_ARB_OUT_REG_EN defined   -> registered one-entry output    |
// |                                          slot, 1 cycle latency, full     |
// |                                          throughput.                     |
// |            L2_ARB_OUT_REG_EN undefined -> combinational pass-through,    |
// |                                          no state.                       |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            data_req_i/add_i/wen_i/wdata_i/be_i  per-master requests      |
// |            data_gnt_o                           per-master grant         |
// |            rr_flag_i                            priority start index     |
// |            data_req_o/add_o/wen_o/wdata_o/be_o  request to bank          |
// |            data_ID_o                            one-hot request source   |
// |            data_gnt_i                           bank grant               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rr_arb_req_l2
  import l2_arb_pkg::*;
#(
  parameter int N_CH       = L2_N_CH_DEF,
  parameter int ADDR_WIDTH = L2_ADDR_W_DEF,
  parameter int DATA_WIDTH = L2_DATA_W_DEF,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int FLAG_W     = $clog2(N_CH)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_CH-1:0]                      data_req_i,
  input  logic [N_CH-1:0][ADDR_WIDTH-1:0]      data_add_i,
  input  logic [N_CH-1:0]                      data_wen_i,
  input  logic [N_CH-1:0][DATA_WIDTH-1:0]      data_wdata_i,
  input  logic [N_CH-1:0][BE_WIDTH-1:0]        data_be_i,
  output logic [N_CH-1:0]                      data_gnt_o,
  input  logic [FLAG_W-1:0]                    rr_flag_i,
  output logic                                 data_req_o,
  output logic [ADDR_WIDTH-1:0]                data_add_o,
  output logic                                 data_wen_o,
  output logic [DATA_WIDTH-1:0]                data_wdata_o,
  output logic [BE_WIDTH-1:0]                  data_be_o,
  output logic [N_CH-1:0]                      data_ID_o,
  input  logic                                 data_gnt_i
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]       w_win_oh;
  logic [IDX_W-1:0]      w_win_idx;
  logic                  w_win_valid;
  logic [ADDR_WIDTH-1:0] w_win_add;
  logic                  w_win_wen;
  logic [DATA_WIDTH-1:0] w_win_wdata;
  logic [BE_WIDTH-1:0]   w_win_be;

  rr_prio_sel_l2 #(
    .N_CH   (N_CH),
    .FLAG_W (FLAG_W),
    .IDX_W  (IDX_W)
  ) u_prio_sel (
    .req       (data_req_i),
    .flag      (rr_flag_i),
    .gnt_oh    (w_win_oh),
    .gnt_idx   (w_win_idx),
    .gnt_valid (w_win_valid)
  );

  // Winner payload mux; with no winner the index is 0 and the payload is
  // a don't-care that no consumer samples.
  assign w_win_add   = data_add_i[w_win_idx];
  assign w_win_wen   = data_wen_i[w_win_idx];
  assign w_win_wdata = data_wdata_i[w_win_idx];
  assign w_win_be    = data_be_i[w_win_idx];

`ifdef L2_ARB_OUT_REG_EN

  logic                  r_valid;
  logic [N_CH-1:0]       r_id;
  logic [ADDR_WIDTH-1:0] r_add;
  logic                  r_wen;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BE_WIDTH-1:0]   r_be;
  logic                  w_load;

  // The slot can accept a new entry when empty or when its current entry is
  // leaving this cycle; the latter keeps one transfer per cycle.
  assign w_load     = ~r_valid | data_gnt_i;
  assign data_gnt_o = w_win_oh & {N_CH{w_load}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_add   <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_load) begin
      r_valid <= w_win_valid;
      // w_win_oh is all-zero without a winner, so an emptied slot reports ID 0.
      r_id    <= w_win_oh;
      if (w_win_valid) begin
        r_add   <= w_win_add;
        r_wen   <= w_win_wen;
        r_wdata <= w_win_wdata;
        r_be    <= w_win_be;
      end
    end
  end

  assign data_req_o   = r_valid;
  assign data_ID_o    = r_id;
  assign data_add_o   = r_add;
  assign data_wen_o   = r_wen;
  assign data_wdata_o = r_wdata;
  assign data_be_o    = r_be;

`else

  // Pure pass-through: the bank grant is steered straight back to the winner.
  assign data_req_o   = |data_req_i;
  assign data_gnt_o   = w_win_oh & {N_CH{data_gnt_i}};
  assign data_ID_o    = w_win_oh;
  assign data_add_o   = w_win_add;
  assign data_wen_o   = w_win_wen;
  assign data_wdata_o = w_win_wdata;
  assign data_be_o    = w_win_be;

  // Clock and reset have no load in this build.
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk ^ rst_n;

`endif

endmodule : rr_arb_req_l2
`default_nettype wire

// File: tb/tb_rr_arb_req_l2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rr_arb_req_l2                                              |
// | Purpose  : Self-checking bench for rr_arb_req_l2 (N_CH = 4). Directed    |
// |            vectors push expected bank requests into a queue; a monitor   |
// |            compares whatever the DUT presents on the bank side.          |
// |            Follows L2_ARB_OUT_REG_EN the same way the design does.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_rr_arb_req_l2;

  localparam int N_CH = 4;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int FW   = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [N_CH-1:0]           data_req_i;
  logic [N_CH-1:0][AW-1:0]   data_add_i;
  logic [N_CH-1:0]           data_wen_i;
  logic [N_CH-1:0][DW-1:0]   data_wdata_i;
  logic [N_CH-1:0][BW-1:0]   data_be_i;
  logic [N_CH-1:0]           data_gnt_o;
  logic [FW-1:0]             rr_flag_i;
  logic                      data_req_o;
  logic [AW-1:0]             data_add_o;
  logic                      data_wen_o;
  logic [DW-1:0]             data_wdata_o;
  logic [BW-1:0]             data_be_o;
  logic [N_CH-1:0]           data_ID_o;
  logic                      data_gnt_i;

  rr_arb_req_l2 #(
    .N_CH       (N_CH),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BE_WIDTH   (BW),
    .FLAG_W     (FW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_req_i   (data_req_i),
    .data_add_i   (data_add_i),
    .data_wen_i   (data_wen_i),
    .data_wdata_i (data_wdata_i),
    .data_be_i    (data_be_i),
    .data_gnt_o   (data_gnt_o),
    .rr_flag_i    (rr_flag_i),
    .data_req_o   (data_req_o),
    .data_add_o   (data_add_o),
    .data_wen_o   (data_wen_o),
    .data_wdata_o (data_wdata_o),
    .data_be_o    (data_be_o),
    .data_ID_o    (data_ID_o),
    .data_gnt_i   (data_gnt_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_CH-1:0] id;
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW-1:0]   wdata;
    logic [BW-1:0]   be;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Distinct payload per master and per vector tag, so a wrong mux select
  // or a slot that fails to hold is visible.
  function automatic exp_t payload_of(input int m, input int tag);
    exp_t e;
    e.id    = N_CH'(1) << m;
    e.add   = AW'(tag * 16 + m + 1);
    e.wen   = 1'((m + tag) % 2);
    e.wdata = DW'(tag * 256 + m) ^ 32'hA5A5_0000;
    e.be    = BW'(m + tag + 1);
    return e;
  endfunction

  function automatic int idx_of(input logic [N_CH-1:0] oh);
    int r = 0;
    for (int i = 0; i < N_CH; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic drive_payload(input int tag);
    exp_t p;
    for (int m = 0; m < N_CH; m++) begin
      p = payload_of(m, tag);
      data_add_i[m]   = p.add;
      data_wen_i[m]   = p.wen;
      data_wdata_i[m] = p.wdata;
      data_be_i[m]    = p.be;
    end
  endtask

  // One cycle of stimulus. exp_gnt: hand-computed data_gnt_o this cycle.
  // exp_win: one-hot of the request the bank side is expected to present
  // for this vector (0 = nothing new).
  task automatic step(input string name, input logic [FW-1:0] flag, input logic [N_CH-1:0] req,
                      input logic gi, input logic [N_CH-1:0] exp_gnt,
                      input logic [N_CH-1:0] exp_win, input int tag);
    @(posedge clk);
    #1;
    rr_flag_i  = flag;
    data_req_i = req;
    data_gnt_i = gi;
    drive_payload(tag);
    #2;
    check($sformatf("%s.gnt_o", name), 64'(data_gnt_o), 64'(exp_gnt));
`ifndef L2_ARB_OUT_REG_EN
    check($sformatf("%s.req_o", name), 64'(data_req_o), 64'(exp_win != '0));
    check($sformatf("%s.id_o", name), 64'(data_ID_o), 64'(exp_win));
`endif
    if (exp_win != '0) exp_q.push_back(payload_of(idx_of(exp_win), tag));
  endtask

  // Monitor: compares the presented bank request against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && data_req_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("mon.unexpected_req", 64'(data_ID_o), 64'd0);
        end else begin
          e = exp_q[0];
          check("mon.id", 64'(data_ID_o), 64'(e.id));
          check("mon.payload", 64'({data_add_o, data_wen_o, data_wdata_o, data_be_o}),
                64'({e.add, e.wen, e.wdata, e.be}));
`ifdef L2_ARB_OUT_REG_EN
          if (data_gnt_i === 1'b1) void'(exp_q.pop_front());
`else
          void'(exp_q.pop_front());
`endif
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    data_req_i = '0;
    data_gnt_i = 1'b0;
    rr_flag_i  = '0;
    drive_payload(0);
    repeat (2) @(posedge clk);
    #1;
    check("reset.req_o", 64'(data_req_o), 64'd0);
    check("reset.id_o", 64'(data_ID_o), 64'd0);
    check("reset.gnt_o", 64'(data_gnt_o), 64'd0);
`ifdef L2_ARB_OUT_REG_EN
    check("reset.add_o", 64'(data_add_o), 64'd0);
`endif
    #1;
    rst_n = 1'b1;

`ifdef L2_ARB_OUT_REG_EN
    step("r1_flag2",   2'd2, 4'b1011, 1'b1, 4'b1000, 4'b1000, 1);
    step("r2_wrap",    2'd3, 4'b0011, 1'b1, 4'b0001, 4'b0001, 2);
    step("r3_stall",   2'd0, 4'b0100, 1'b0, 4'b0000, 4'b0000, 3);
    step("r4_stall",   2'd1, 4'b0110, 1'b0, 4'b0000, 4'b0000, 4);
    step("r5_stall",   2'd2, 4'b1000, 1'b0, 4'b0000, 4'b0000, 5);
    step("r6_release", 2'd0, 4'b1000, 1'b1, 4'b1000, 4'b1000, 6);
    step("r7_full",    2'd0, 4'b1111, 1'b1, 4'b0001, 4'b0001, 7);
    step("r8_full",    2'd1, 4'b1111, 1'b1, 4'b0010, 4'b0010, 8);
    step("r9_full",    2'd2, 4'b1111, 1'b1, 4'b0100, 4'b0100, 9);
    step("r10_full",   2'd3, 4'b1111, 1'b1, 4'b1000, 4'b1000, 10);
    step("r11_drain",  2'd0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 11);
    step("r12_idle",   2'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 12);
    check("r12.req_o_empty", 64'(data_req_o), 64'd0);
    check("r12.id_o_empty", 64'(data_ID_o), 64'd0);
    step("r13_load",   2'd0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 13);
    step("r14_hold",   2'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 14);
    check("r14.req_o_held", 64'(data_req_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid.req_o", 64'(data_req_o), 64'd0);
    check("rst_mid.id_o", 64'(data_ID_o), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step("r15_after_rst", 2'd0, 4'b0100, 1'b1, 4'b0100, 4'b0100, 15);
    step("r16_drain",     2'd0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 16);
    step("r17_idle",      2'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 17);
`else
    step("c1_flag2",  2'd2, 4'b1011, 1'b1, 4'b1000, 4'b1000, 1);
    step("c2_wrap",   2'd3, 4'b0011, 1'b1, 4'b0001, 4'b0001, 2);
    step("c3_flag0",  2'd0, 4'b0110, 1'b1, 4'b0010, 4'b0010, 3);
    step("c4_wrap",   2'd1, 4'b0001, 1'b1, 4'b0001, 4'b0001, 4);
    step("c5_single", 2'd2, 4'b0100, 1'b1, 4'b0100, 4'b0100, 5);
    step("c6_all",    2'd1, 4'b1111, 1'b1, 4'b0010, 4'b0010, 6);
    step("c7_nognt",  2'd0, 4'b1000, 1'b0, 4'b0000, 4'b1000, 7);
    step("c8_noreq",  2'd0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 8);
    step("c9_top",    2'd3, 4'b1000, 1'b1, 4'b1000, 4'b1000, 9);
    step("c10_top",   2'd3, 4'b1001, 1'b1, 4'b1000, 4'b1000, 10);
    step("c11_wrap",  2'd2, 4'b0011, 1'b1, 4'b0001, 4'b0001, 11);
    step("c12_full",  2'd0, 4'b1111, 1'b1, 4'b0001, 4'b0001, 12);
    step("c13_full",  2'd1, 4'b1111, 1'b1, 4'b0010, 4'b0010, 13);
    step("c14_full",  2'd2, 4'b1111, 1'b1, 4'b0100, 4'b0100, 14);
    step("c15_full",  2'd3, 4'b1111, 1'b1, 4'b1000, 4'b1000, 15);
    step("c16_idle",  2'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 16);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rr_arb_req_l2
`default_nettype wire

// File: doc/rr_arb_req_l2.md
RR_ARB_REQ_L2 -- requirements
Module: rr_arb_req_l2

Interface
REQ-001 Parameter N_CH, default 4, number of requesting masters (2..16).
REQ-002 Parameter ADDR_WIDTH, default 12, bank word address width.
REQ-003 Parameter DATA_WIDTH, default 32, write data width; BE_WIDTH = DATA_WIDTH/8.
REQ-004 Parameter FLAG_W, default $clog2(N_CH), width of round-robin flag.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 data_req_i  in  N_CH  per-master request.
REQ-008 data_add_i  in  N_CH x ADDR_WIDTH  per-master address.
REQ-009 data_wen_i  in  N_CH  per-master write-enable, 0=write, 1=read.
REQ-010 data_wdata_i  in  N_CH x DATA_WIDTH  per-master write data.
REQ-011 data_be_i  in  N_CH x BE_WIDTH  per-master byte enables.
REQ-012 data_gnt_o  out  N_CH  per-master grant, one-hot or zero.
REQ-013 rr_flag_i  in  FLAG_W  highest-priority master index from round-robin flag counter.
REQ-014 data_req_o / data_add_o / data_wen_o / data_wdata_o / data_be_o  out  1/ADDR/1/DATA/BE  request to bank.
REQ-015 data_ID_o  out  N_CH  one-hot source of the presented request.
REQ-016 data_gnt_i  in  1  bank grant; data_req_o & data_gnt_i = transfer (also drives flag counter).

Function
REQ-017 Winner SHALL be first asserted data_req_i scanning from index rr_flag_i upward, wrapping N_CH-1 -> 0.
REQ-018 rr_flag_i >= N_CH SHALL be treated as 0.
REQ-019 No request asserted -> no winner, data_gnt_o = 0.
REQ-020 Output slot (registered): load enabled when slot empty or current slot transfers (data_req_o & data_gnt_i).
REQ-021 When load enabled and winner exists: data_gnt_o[winner]=1 same cycle; winner payload and one-hot ID captured; data_req_o=1 next cycle.
REQ-022 When load enabled and no winner: slot empties next cycle (data_req_o=0).
REQ-023 Slot valid and data_gnt_i=0: all data_*_o and data_ID_o SHALL hold stable, data_gnt_o = 0.
REQ-024 Back-to-back: transfer and new capture in same cycle SHALL sustain one request per cycle.
REQ-025 At most one data_gnt_o bit SHALL be high in any cycle.
REQ-026 Latency: master request to data_req_o = 1 cycle (registered mode).
REQ-027 Payload outputs when data_req_o=0 are don't-care; data_ID_o SHALL be 0.

Reset
REQ-028 rst_n low: slot empty, data_req_o=0, data_ID_o=0, payload registers 0, asynchronously.
REQ-029 Reset mid-transfer SHALL drop the held request; no grant reissued; masters must re-request.
REQ-030 First cycle after reset release SHALL accept a new winner.

Configuration
REQ-031 Macro L2_ARB_OUT_REG_EN defined: registered slot per REQ-020..REQ-026.
REQ-032 Macro undefined: combinational pass-through; data_*_o = winner payload, data_req_o = |data_req_i, data_gnt_o[winner] = data_gnt_i, latency 0, no state.

Structure
REQ-033 Package l2_arb_pkg SHALL hold req_payload_t (add, wen, wdata, be) and default width constants.
REQ-034 Sub-module rr_prio_sel_l2 SHALL implement the combinational rotate-priority winner select (one-hot + valid).

Verification
REQ-035 N_CH=4, rr_flag_i=2, data_req_i=4'b1011 -> data_gnt_o=4'b1000, next cycle data_ID_o=4'b1000.
REQ-036 rr_flag_i=3, data_req_i=4'b0011 -> wrap, data_gnt_o=4'b0001.
REQ-037 Slot valid, data_gnt_i=0 for 3 cycles, requests changing -> outputs stable, data_gnt_o=0; data_gnt_i=1 -> next winner granted same cycle.
REQ-038 All four masters request continuously, data_gnt_i=1, flag counting 0..3 -> one transfer per cycle, IDs 1,2,4,8 cyclic.
REQ-039 rst_n low while data_req_o=1 -> data_req_o=0 immediately, data_ID_o=0.
REQ-040 Build without L2_ARB_OUT_REG_EN, data_req_i=4'b0100, data_gnt_i=1 -> data_gnt_o=4'b0100 same cycle, data_req_o=1.
